// File: rtl/alu_op_sequencer_if.sv
// One-hot operation-strobe bus between the ALU sequencer (master) and the ALU (slave).
// Signal names are given from the sequencer's point of view.
interface alu_op_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic                 and_o;
  logic                 or_o;
  logic                 add_o;
  logic                 sub_o;
  logic                 mul_o;
  logic                 div_o;
  logic                 shr_o;
  logic                 shl_o;
  logic                 ror_o;
  logic                 rol_o;
  logic                 neg_o;
  logic                 not_o;
  logic [WIDTH-1:0]     alu_a_o;
  logic [WIDTH-1:0]     alu_b_o;
  logic [2*WIDTH-1:0]   alu_c_i;

  modport master (
    output and_o, or_o, add_o, sub_o, mul_o, div_o,
    output shr_o, shl_o, ror_o, rol_o, neg_o, not_o,
    output alu_a_o, alu_b_o,
    input  alu_c_i
  );

  modport slave (
    input  and_o, or_o, add_o, sub_o, mul_o, div_o,
    input  shr_o, shl_o, ror_o, rol_o, neg_o, not_o,
    input  alu_a_o, alu_b_o,
    output alu_c_i
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issues one ALU strobe per request, captures the 64-bit result and runs signed DIV locally.
// Optional done counter (stat_ops_o) is enabled by defining ALU_SEQ_STATS_EN.
module alu_op_sequencer #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [3:0]           op_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [WIDTH-1:0]     zhi_o,
  output logic [WIDTH-1:0]     zlo_o,
`ifdef ALU_SEQ_STATS_EN
  output logic [15:0]          stat_ops_o,
`endif
  alu_op_sequencer_if.master   alu_io
);

  localparam logic [3:0] OpDiv = 4'd5;
  localparam logic [3:0] OpNot = 4'd11;

  localparam int unsigned CntW = $clog2(WIDTH + ALU_LAT + 1);
  localparam logic [CntW-1:0] LatLast = CntW'(ALU_LAT - 1);
  localparam logic [CntW-1:0] DivLast = CntW'(WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StCapture,
    StDivide,
    StDfix,
    StFinish
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] zhi_q, zhi_d;
  logic [WIDTH-1:0] zlo_q, zlo_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;
  logic             trial_neg;
  logic             unused_diff;
  logic [11:0]      stb;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  // Restoring step: the quotient register doubles as the dividend shift source.
  assign rem_sh      = {rem_q, quo_q[WIDTH-1]};
  assign diff        = {1'b0, rem_sh} - {2'b00, dvs_q};
  assign trial_neg   = diff[WIDTH+1];
  assign unused_diff = diff[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      err_q   <= 1'b0;
      zhi_q   <= '0;
      zlo_q   <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      err_q   <= err_d;
      zhi_q   <= zhi_d;
      zlo_q   <= zlo_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    err_d   = err_q;
    zhi_d   = zhi_q;
    zlo_d   = zlo_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          op_d  = op_i;
          a_d   = a_i;
          b_d   = b_i;
          cnt_d = '0;
          err_d = 1'b0;
          if (op_i > OpNot) begin
            err_d   = 1'b1;
            state_d = StFinish;
          end else if (op_i == OpDiv) begin
            if (b_i == '0) begin
              err_d   = 1'b1;
              zhi_d   = a_i;
              zlo_d   = '1;
              state_d = StFinish;
            end else begin
              rem_d   = '0;
              quo_d   = mag(a_i);
              dvs_d   = mag(b_i);
              state_d = StDivide;
            end
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LatLast) begin
          state_d = StCapture;
        end
      end
      StCapture: begin
        {zhi_d, zlo_d} = alu_io.alu_c_i;
        state_d        = StFinish;
      end
      StDivide: begin
        rem_d = trial_neg ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ~trial_neg};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == DivLast) begin
          state_d = StDfix;
        end
      end
      StDfix: begin
        zlo_d   = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -quo_q : quo_q;
        zhi_d   = a_q[WIDTH-1] ? -rem_q : rem_q;
        state_d = StFinish;
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Strobe index equals opcode; DIV and illegal opcodes never reach StIssue.
  always_comb begin
    stb    = '0;
    busy_o = (state_q != StIdle) && (state_q != StFinish);
    done_o = (state_q == StFinish);
    if ((state_q == StIssue) && (op_q <= OpNot) && (op_q != OpDiv)) begin
      stb[op_q] = 1'b1;
    end
  end

  assign alu_io.and_o   = stb[0];
  assign alu_io.or_o    = stb[1];
  assign alu_io.add_o   = stb[2];
  assign alu_io.sub_o   = stb[3];
  assign alu_io.mul_o   = stb[4];
  assign alu_io.div_o   = stb[5];
  assign alu_io.shr_o   = stb[6];
  assign alu_io.shl_o   = stb[7];
  assign alu_io.ror_o   = stb[8];
  assign alu_io.rol_o   = stb[9];
  assign alu_io.neg_o   = stb[10];
  assign alu_io.not_o   = stb[11];
  assign alu_io.alu_a_o = a_q;
  assign alu_io.alu_b_o = b_q;

  assign err_o = err_q;
  assign zhi_o = zhi_q;
  assign zlo_o = zlo_q;

`ifdef ALU_SEQ_STATS_EN
  logic [15:0] stat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q <= '0;
    end else if (done_o && (stat_q != 16'hFFFF)) begin
      stat_q <= stat_q + 16'd1;
    end
  end

  assign stat_ops_o = stat_q;
`endif

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Initiator and control side of the 32-bit ALU's one-hot operation-strobe interface.
- Accepts an encoded opcode plus operands and drives exactly one ALU strobe for the required number of cycles.
- Captures the ALU's registered 64-bit result into Zhi/Zlo, then pulses done.
- The ALU has no divide datapath, so this block implements DIV itself as a multi-cycle signed restoring divider.

Parameters:
- WIDTH, 32, operand width; ALU result width is 2*WIDTH.
- ALU_LAT, 1, number of consecutive cycles a strobe is held high; the ALU result is valid the cycle after the last strobe cycle.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  request; sampled only in IDLE.
- op_i  in  4  opcode: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 MUL, 5 DIV, 6 SHR, 7 SHL, 8 ROR, 9 ROL, 10 NEG, 11 NOT; 12-15 illegal.
- a_i  in  WIDTH  operand A.
- b_i  in  WIDTH  operand B.
- busy_o  out  1  high from the accept edge until done_o is asserted.
- done_o  out  1  one-cycle pulse; zhi_o/zlo_o/err_o are valid in the same cycle.
- err_o  out  1  illegal opcode or divide-by-zero; held until the next accept.
- and_o, or_o, add_o, sub_o, mul_o, div_o, shr_o, shl_o, ror_o, rol_o, neg_o, not_o  out  1 each  ALU strobes; at most one high in any cycle.
- alu_a_o  out  WIDTH  latched A, stable from the accept edge until the next accept.
- alu_b_o  out  WIDTH  latched B, same stability rule as alu_a_o.
- alu_c_i  in  2*WIDTH  ALU result.
- zhi_o  out  WIDTH  result bits [2W-1:W].
- zlo_o  out  WIDTH  result bits [W-1:0].

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - All strobes, busy_o, done_o and err_o go to 0.
  - zhi_o, zlo_o, alu_a_o and alu_b_o go to 0.
  - State returns to IDLE; any divider progress is discarded.
- States: IDLE, ISSUE, CAPTURE, DIVIDE, DFIX, FINISH.
- IDLE:
  - start_i=1 accepts the request: latch op, a_i and b_i; busy_o goes to 1 on the next cycle.
  - Illegal opcode: go to FINISH with err=1; zhi/zlo unchanged; no strobe issued.
  - op 5 (DIV), b_i=0: go to FINISH with err=1, zhi=a, zlo=all ones.
  - op 5 (DIV), b_i nonzero: go to DIVIDE.
  - Any other legal op: go to ISSUE.
- ISSUE:
  - Assert the decoded strobe for exactly ALU_LAT cycles, then go to CAPTURE.
  - div_o is never asserted.
- CAPTURE: register alu_c_i into {zhi, zlo}, then go to FINISH.
- DIVIDE:
  - Operate on magnitudes |A| and |B|, one quotient bit per cycle, WIDTH cycles, MSB first.
  - Restoring step: shift remainder left, subtract divisor, restore if the result is negative.
- DFIX:
  - Negate the quotient if sign(A) differs from sign(B).
  - The remainder takes the sign of A.
  - zlo = quotient, zhi = remainder; go to FINISH.
- FINISH: done_o=1 for one cycle, busy_o=0 in that same cycle, go to IDLE.
- Latency from the accept edge to done_o high:
  - ALU ops: ALU_LAT+2 cycles.
  - DIV: WIDTH+2 cycles.
  - Illegal opcode or divide-by-zero: 1 cycle.
- Overlapping requests: start_i while not in IDLE is ignored, not queued.
- Back-to-back requests: start_i may be accepted in the cycle immediately after done_o.
- Boundary cases:
  - 0x80000000 / 0xFFFFFFFF gives zlo=0x80000000, zhi=0 (wraps, err_o=0).
  - Signed/unsigned semantics of all non-DIV ops belong to the ALU; this block passes alu_c_i through unmodified.

Optional Feature:
- Macro ALU_SEQ_STATS_EN.
- When defined:
  - Adds output stat_ops_o, 16 bits.
  - Counts every done_o pulse, including errors; saturates at 0xFFFF.
  - Cleared by reset.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- ADD, A=5, B=7, ALU_LAT=1 → add_o high for exactly 1 cycle, no other strobe; done_o 3 cycles after accept; zlo=0x0000000C, zhi=0, err_o=0.
- MUL, A=0x00010000, B=0x00010000 → mul_o 1 cycle; zhi=0x00000001, zlo=0x00000000.
- DIV, A=-7 (0xFFFFFFF9), B=2 → no ALU strobe; done_o 34 cycles after accept; zlo=0xFFFFFFFD, zhi=0xFFFFFFFF.
- DIV, A=9, B=0 → done_o 1 cycle after accept; err_o=1, zhi=9, zlo=0xFFFFFFFF.
- Illegal op 13 → done_o after 1 cycle, err_o=1, zhi/zlo unchanged.
- start_i held high during a DIV → second request ignored.
- rst_n low at DIVIDE cycle 10 → busy_o=0 and all strobes low immediately; the next request runs normally.
- Stats build: 3 completed ops → stat_ops_o=3.
